// File: rtl/prd_sched_pkg.sv
// Shared types and helpers for the period-measurement scan scheduler.
// Provides the FSM state encoding, the result width and the round-robin channel search.
package prd_sched_pkg;

  localparam int PRD_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_START,
    ST_WAIT,
    ST_STORE,
    ST_ABORT
  } state_e;

  // Returns the first set mask bit after cur, wrapping modulo n.
  // cur itself is the last candidate tried. If no bit is set, cur is returned.
  function automatic logic [3:0] rr_next(input logic [15:0] mask, input logic [3:0] cur,
                                         input int n);
    logic [3:0] res;
    logic       found;
    int         idx;
    res   = cur;
    found = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      idx = (int'(cur) + i) % n;
      if (i <= n && !found && mask[idx]) begin
        res   = idx[3:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ms_timer.sv
// Clock-to-millisecond timer: t wraps every CLK_MS_COUNT clocks while run is high,
// and each wrap advances ms. clr zeroes both counters and takes priority over run.
module ms_timer #(
  parameter int CLK_MS_COUNT = 100000,
  parameter int T_W          = 17,
  parameter int MS_W         = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            run,
  output logic [MS_W-1:0] ms
);

  logic [T_W-1:0]  t_q, t_d;
  logic [MS_W-1:0] ms_q, ms_d;

  always_comb begin
    t_d  = t_q;
    ms_d = ms_q;
    if (clr) begin
      t_d  = '0;
      ms_d = '0;
    end else if (run) begin
      if (t_q == T_W'(CLK_MS_COUNT - 1)) begin
        t_d  = '0;
        ms_d = ms_q + MS_W'(1);
      end else begin
        t_d = t_q + T_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_q  <= '0;
      ms_q <= '0;
    end else begin
      t_q  <= t_d;
      ms_q <= ms_d;
    end
  end

  assign ms = ms_q;

endmodule

// File: rtl/prd_scan_scheduler.sv
// Round-robin scheduler that shares one period-measurement engine across N_CH inputs.
// Each measured channel ends in a stored result or a timeout flag in the result file.
module prd_scan_scheduler
  import prd_sched_pkg::*;
#(
  parameter  int N_CH         = 4,
  parameter  int CLK_MS_COUNT = 100000,
  parameter  int TIMEOUT_MS   = 2100,
  localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH-1:0]       si_in,
  input  logic                  eng_ready,
  input  logic                  eng_done,
  input  logic [PRD_W-1:0]      eng_prd,
  output logic                  eng_start,
  output logic                  eng_abort,
  output logic                  eng_si,
  output logic [PRD_W*N_CH-1:0] prd_all,
  output logic [N_CH-1:0]       valid,
  output logic [N_CH-1:0]       tmo,
  output logic [CH_W-1:0]       cur_ch,
  output logic                  upd_tick,
  output logic                  busy
);

  // Engine handshake: eng_start is issued only from START, on a cycle where eng_ready is high.
  // The engine then owns the channel until it pulses eng_done, or until eng_abort returns it to idle.
  state_e                 state_q, state_d;
  logic [CH_W-1:0]        cur_ch_q, cur_ch_d;
  logic [PRD_W*N_CH-1:0]  prd_all_q, prd_all_d;
  logic [N_CH-1:0]        valid_q, valid_d;
  logic [N_CH-1:0]        tmo_q, tmo_d;
  logic                   eng_start_q, eng_start_d;
  logic                   eng_abort_q, eng_abort_d;
  logic                   upd_tick_q, upd_tick_d;
  logic                   busy_q, busy_d;
  logic                   tmr_clr, tmr_run;
  logic [11:0]            ms;

  assign tmr_run = (state_q == ST_WAIT);

  ms_timer #(
    .CLK_MS_COUNT(CLK_MS_COUNT),
    .T_W         (17),
    .MS_W        (12)
  ) u_ms_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (tmr_clr),
    .run  (tmr_run),
    .ms   (ms)
  );

  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    prd_all_d   = prd_all_q;
    valid_d     = valid_q;
    tmo_d       = tmo_q;
    eng_start_d = 1'b0;
    eng_abort_d = 1'b0;
    upd_tick_d  = 1'b0;
    tmr_clr     = 1'b0;
    case (state_q)
      ST_IDLE: if (en && |ch_en) state_d = ST_SELECT;
      ST_SELECT: begin
        if (ch_en == '0) begin
          state_d = ST_IDLE;
        end else begin
          cur_ch_d = CH_W'(rr_next(16'(ch_en), 4'(cur_ch_q), N_CH));
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (eng_ready) begin
          eng_start_d = 1'b1;
          tmr_clr     = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A done arriving on the timeout cycle still wins.
        if (eng_done) begin
          prd_all_d[cur_ch_q*PRD_W +: PRD_W] = eng_prd;
          valid_d[cur_ch_q] = 1'b1;
          tmo_d[cur_ch_q]   = 1'b0;
          upd_tick_d        = 1'b1;
          state_d           = ST_STORE;
        end else if (ms == 12'(TIMEOUT_MS)) begin
          valid_d[cur_ch_q] = 1'b0;
          tmo_d[cur_ch_q]   = 1'b1;
          upd_tick_d        = 1'b1;
          eng_abort_d       = 1'b1;
          state_d           = ST_ABORT;
        end
      end
      ST_STORE, ST_ABORT: state_d = en ? ST_SELECT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_ch_q    <= CH_W'(N_CH - 1);
      prd_all_q   <= '0;
      valid_q     <= '0;
      tmo_q       <= '0;
      eng_start_q <= 1'b0;
      eng_abort_q <= 1'b0;
      upd_tick_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      prd_all_q   <= prd_all_d;
      valid_q     <= valid_d;
      tmo_q       <= tmo_d;
      eng_start_q <= eng_start_d;
      eng_abort_q <= eng_abort_d;
      upd_tick_q  <= upd_tick_d;
      busy_q      <= busy_d;
    end
  end

  assign eng_si    = si_in[cur_ch_q];
  assign eng_start = eng_start_q;
  assign eng_abort = eng_abort_q;
  assign prd_all   = prd_all_q;
  assign valid     = valid_q;
  assign tmo       = tmo_q;
  assign cur_ch    = cur_ch_q;
  assign upd_tick  = upd_tick_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_prd_scan_scheduler.sv
// Bench for prd_scan_scheduler: periodic channel signals, an edge-measuring engine model,
// and a scoreboard that checks every result/timeout store against an expected queue.
module tb_prd_scan_scheduler;

  localparam int N_CH = 4;
  localparam int CMS  = 10;
  localparam int TMO  = 30;
  localparam int EW   = 13;  // {ch[1:0], tmo, prd[9:0]}

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic [N_CH-1:0] ch_en;
  logic [N_CH-1:0] si_in = '0;
  logic            eng_ready;
  logic            eng_done;
  logic [9:0]      eng_prd;
  logic            eng_start, eng_abort, eng_si, upd_tick, busy;
  logic [10*N_CH-1:0] prd_all;
  logic [N_CH-1:0] valid, tmo;
  logic [1:0]      cur_ch;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int abort_cnt = 0;
  int last_upd_cyc = -1;
  int last_start_cyc = 0;
  logic [EW-1:0] exp_q[$];

  int per [N_CH] = '{5, 7, 0, 12};  // channel periods in ms; 0 = held low
  int gen_ctr [N_CH] = '{0, 0, 0, 0};
  logic force_done = 1'b0;

  int   e_st = 0;
  int   e_cnt = 0;
  logic e_prev = 1'b0;

  prd_scan_scheduler #(
    .N_CH        (N_CH),
    .CLK_MS_COUNT(CMS),
    .TIMEOUT_MS  (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .ch_en    (ch_en),
    .si_in    (si_in),
    .eng_ready(eng_ready),
    .eng_done (eng_done),
    .eng_prd  (eng_prd),
    .eng_start(eng_start),
    .eng_abort(eng_abort),
    .eng_si   (eng_si),
    .prd_all  (prd_all),
    .valid    (valid),
    .tmo      (tmo),
    .cur_ch   (cur_ch),
    .upd_tick (upd_tick),
    .busy     (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- channel signal generators ----------------
  always @(posedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (per[k] == 0) begin
        gen_ctr[k] <= 0;
        si_in[k]   <= 1'b0;
      end else begin
        gen_ctr[k] <= (gen_ctr[k] + 1) % (per[k] * CMS);
        si_in[k]   <= (gen_ctr[k] < per[k] * CMS / 2);
      end
    end
  end

  // ---------------- engine model: rising edge to rising edge of eng_si ----------------
  always @(negedge clk) begin
    if (reset) begin
      e_st      <= 0;
      e_cnt     <= 0;
      eng_ready <= 1'b1;
      eng_done  <= 1'b0;
      eng_prd   <= '0;
    end else begin
      eng_done <= 1'b0;
      case (e_st)
        0: if (eng_start) begin
          e_st      <= 1;
          e_cnt     <= 0;
          eng_ready <= 1'b0;
        end
        1: begin
          if (eng_abort) begin
            e_st      <= 0;
            eng_ready <= 1'b1;
          end else if (force_done) begin
            e_cnt <= e_cnt + 1;
            if (e_cnt + 1 == TMO * CMS) begin
              eng_done  <= 1'b1;
              eng_prd   <= 10'd777;
              eng_ready <= 1'b1;
              e_st      <= 0;
            end
          end else if (eng_si && !e_prev) begin
            e_st  <= 2;
            e_cnt <= 0;
          end
        end
        default: begin
          if (eng_abort) begin
            e_st      <= 0;
            eng_ready <= 1'b1;
          end else if (eng_si && !e_prev) begin
            eng_done  <= 1'b1;
            eng_prd   <= 10'((e_cnt + 1) / CMS);
            eng_ready <= 1'b1;
            e_st      <= 0;
          end else begin
            e_cnt <= e_cnt + 1;
          end
        end
      endcase
    end
    e_prev <= eng_si;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int ch, input logic t, input int prd);
    exp_q.push_back({2'(ch), t, 10'(prd)});
  endtask

  task automatic wait_empty(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d stores outstanding after %0d cycles, expected 0", name,
               exp_q.size(), limit);
      exp_q.delete();
    end
  endtask

  task automatic wait_start(input string name, input int limit);
    int s = start_cnt;
    int n = 0;
    while (start_cnt == s && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (start_cnt == s) begin
      checks++;
      errors++;
      $display("FAIL %s: no eng_start within %0d cycles", name, limit);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int ch;
    if (eng_start) begin
      start_cnt++;
      last_start_cyc = cyc;
      if (last_upd_cyc >= 0) begin
        checks++;
        if (cyc - last_upd_cyc < 3) begin
          errors++;
          $display("FAIL start_gap: got %0d cycles after store, need >= 3", cyc - last_upd_cyc);
        end
      end
    end
    if (eng_abort) begin
      abort_cnt++;
      check("abort_ms", (cyc - last_start_cyc) / CMS, TMO);
    end
    if (upd_tick) begin
      last_upd_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_store: got store for ch %0d, expected none", cur_ch);
      end else begin
        e  = exp_q.pop_front();
        ch = int'(e[12:11]);
        check("store_ch", cur_ch, e[12:11]);
        check("store_prd", prd_all[ch*10 +: 10], e[9:0]);
        check("store_tmo", tmo[ch], e[10]);
        check("store_valid", valid[ch], !e[10]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int s;
    reset = 1'b1;
    en    = 1'b1;
    ch_en = 4'b1011;
    idle_cycles(5);
    check("rst_prd_all", prd_all, 0);
    check("rst_valid", valid, 0);
    check("rst_tmo", tmo, 0);
    check("rst_cur_ch", cur_ch, 3);
    check("rst_busy", busy, 0);
    check("rst_upd_tick", upd_tick, 0);
    check("rst_abort", eng_abort, 0);
    check("rst_starts", start_cnt, 0);
    reset = 1'b0;

    // Round robin over 0,1,3 with periods 5/7/12 ms
    push_exp(0, 0, 5);
    push_exp(1, 0, 7);
    push_exp(3, 0, 12);
    push_exp(0, 0, 5);
    wait_start("first_start", 20);
    check("first_start_ch", cur_ch, 0);
    wait_empty("rr_scan", 3000);
    en = 1'b0;
    idle_cycles(5);
    check("rr_valid", valid, 4'b1011);
    check("rr_prd_all", prd_all, {10'd12, 10'd0, 10'd7, 10'd5});
    check("rr_tmo", tmo, 0);
    check("rr_busy", busy, 0);

    // en dropped while channel 1 is being measured
    push_exp(1, 0, 7);
    en = 1'b1;
    wait_start("p2_start", 20);
    check("p2_ch", cur_ch, 1);
    idle_cycles(20);
    en = 1'b0;
    wait_empty("en_drop", 1000);
    idle_cycles(3);
    check("en_drop_busy", busy, 0);
    s = start_cnt;
    idle_cycles(100);
    check("no_start_when_off", start_cnt, s);

    // Channel 2 held low: timeout, then the scan moves on to 3 and 0
    ch_en = 4'b1111;
    push_exp(2, 1, 0);
    push_exp(3, 0, 12);
    push_exp(0, 0, 5);
    en = 1'b1;
    wait_empty("timeout_scan", 3000);
    en = 1'b0;
    idle_cycles(5);
    check("tmo_abort_cnt", abort_cnt, 1);
    check("tmo_flags", tmo, 4'b0100);
    check("tmo_valid", valid, 4'b1011);

    // Done on the same cycle as the timeout: store wins
    force_done = 1'b1;
    ch_en = 4'b0001;
    push_exp(0, 0, 777);
    en = 1'b1;
    wait_empty("tie", 1000);
    en = 1'b0;
    idle_cycles(5);
    check("tie_no_abort", abort_cnt, 1);
    force_done = 1'b0;

    // Nothing enabled: stays idle
    ch_en = 4'b0000;
    en = 1'b1;
    s = start_cnt;
    idle_cycles(50);
    check("none_busy", busy, 0);
    check("none_starts", start_cnt, s);

    // Single channel measured repeatedly
    per[2] = 9;
    push_exp(2, 0, 9);
    push_exp(2, 0, 9);
    push_exp(2, 0, 9);
    ch_en = 4'b0100;
    wait_empty("single_ch", 3000);
    en = 1'b0;
    idle_cycles(5);
    check("final_valid", valid, 4'b1111);
    check("final_tmo", tmo, 0);
    check("final_prd_all", prd_all, {10'd12, 10'd9, 10'd7, 10'd777});
    check("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
